bus_responder: RTL and testbench
================================

Name: bus_responder

Overview:
Memory-side responder for the 16-bit CPU bus (address, rw, bidirectional data). Provides a zero-wait-state word RAM, a memory-mapped output FIFO drained by an external consumer over a valid/ready handshake, a status register, and an optional free-running timer. It sits opposite the CPU on the same bus, and is the only other driver of data.

Parameters:
DEPTH, 1024, RAM size in 16-bit words; power of two, at most 32768.
FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.
IO_BASE, 16'hFFF0, base address of the 4-word I/O window.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
address  input  16  word address from the CPU.
rw  input  1  1 = CPU write (CPU drives data), 0 = CPU read (responder drives data).
data  inout  16  shared bus data.
out_data  output  16  head of the output FIFO.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts out_data when high together with out_valid.

Behaviour:
- Bus drive: data is driven only when rw=0 and reset=0; otherwise it is high-Z. Reads are combinational (zero wait state), so the CPU samples valid data at the same rising edge.
- Decode:
  - RAM: address < DEPTH, indexed by address[log2(DEPTH)-1:0].
  - IO_BASE+0 OUT_DATA; IO_BASE+1 STATUS; IO_BASE+2 TIMER; IO_BASE+3 reserved.
  - Unmapped and reserved reads return 16'h0000; writes to them are ignored.
- RAM: written at the rising edge when rw=1 and address is in range. Read-during-write returns the old word. Contents are not reset.
- OUT_DATA write: pushes data into the FIFO. If the FIFO is full and no pop happens in the same cycle, the push is dropped and STATUS.ovf is set (sticky). OUT_DATA reads return 16'h0000.
- FIFO:
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop: both take effect, count is unchanged. This applies when full (the push is accepted) and when count=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is 16'h0000 when empty.
- STATUS read: bit0 full, bit1 empty, bit2 ovf, bits[7:4] count, other bits 0. The read returns the pre-edge state.
  - A STATUS write with data[2]=1 clears ovf (write-1-to-clear). Other bits are ignored.
  - If the clear and a new overflow happen in the same cycle, ovf stays set.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO emptied: count=0, pointers=0.
  - out_valid=0, out_data=16'h0000, ovf=0, timer=0, data high-Z.
  - First operation is allowed on the first edge after deassertion.

Optional Feature:
BUS_RESP_TIMER_EN:
- Defined: TIMER is a 16-bit counter incrementing every cycle, wrapping FFFF to 0000. A TIMER write loads data, and the loaded value is read back on the next cycle. The write takes priority over the increment.
- Undefined: no counter flops are present; TIMER reads 16'h0000 and writes are ignored.

Decomposition:
- Package bus_resp_pkg:
  - I/O offset constants: OFS_OUT=0, OFS_STATUS=1, OFS_TIMER=2.
  - STATUS bit positions: ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_CNT_LO=4.
  - RW_WRITE=1'b1.
- Sub-module out_fifo (parameterised by FIFO_DEPTH):
  - Ports: push, push_data, pop, head, full, empty, count.
  - bus_responder keeps decode, RAM, STATUS/ovf, timer, and tristate.

Test Plan:
- Reset, then write 16'hBEEF to 0x0005 and 16'h1234 to 0x0006, then read 0x0005 -> data=16'hBEEF in the same cycle. Read 0x0800 (DEPTH=1024) -> 16'h0000. With rw=1, data is not driven by the responder.
- out_ready=0, write 0x0001..0x0004 to 0xFFF0 -> STATUS=16'h0041. A fifth write 0x0005 is dropped -> STATUS=16'h0045. Drain with out_ready=1 -> out_data sequence 1,2,3,4, then out_valid=0 and STATUS=16'h0006.
- FIFO full, out_ready=1 and an OUT_DATA write of 0x00AA in the same cycle -> no ovf, count stays 4, 0x00AA emerges last.
- With ovf set, write 16'h0004 to STATUS -> STATUS bit2=0. Clear coinciding with an overflowing push -> bit2 stays 1.
- Assert reset mid-drain with 3 entries queued -> out_valid=0, STATUS=16'h0002 immediately (asynchronous), data high-Z.
- BUS_RESP_TIMER_EN defined: write 16'hFFFE to 0xFFF2, then read 2 cycles later -> 16'h0000 (wrap). Undefined: read -> 16'h0000 always.

Source files
------------

// File: rtl/bus_resp_pkg.sv
// Shared constants and helpers for the bus_responder slice: I/O window
// offsets, STATUS bit layout, bus direction encoding and the STATUS packer.
package bus_resp_pkg;

    // Word offsets inside the 4-word I/O window
    localparam int OFS_OUT    = 0;
    localparam int OFS_STATUS = 1;
    localparam int OFS_TIMER  = 2;

    // STATUS register bit positions
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 4;

    // rw encoding: 1 means the CPU drives the bus
    localparam logic RW_WRITE = 1'b1;

    // Assemble the STATUS word; unlisted bits read as zero
    function automatic logic [15:0] pack_status(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [3:0] cnt);
        logic [15:0] s;
        s                  = 16'h0000;
        s[ST_FULL]         = full;
        s[ST_EMPTY]        = empty;
        s[ST_OVF]          = ovf;
        s[ST_CNT_LO +: 4]  = cnt;
        return s;
    endfunction

endpackage

// File: rtl/bus_responder_out_fifo.sv
// out_fifo: small synchronous FIFO feeding the external consumer.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; otherwise it is silently refused (the parent flags the overflow).
module out_fifo
    import bus_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [15:0] head,
    output logic        full,
    output logic        empty,
    output logic [3:0]  count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic          w_pop;
    logic          w_push;

    assign full   = (r_count == 5'(FIFO_DEPTH));
    assign empty  = (r_count == 5'd0);
    assign w_pop  = pop && !empty;
    // Freeing a slot on this edge makes room for the incoming word
    assign w_push = push && (!full || w_pop);
    assign head   = empty ? 16'h0000 : r_mem[r_rd_ptr];
    // STATUS carries only four count bits
    assign count  = r_count[3:0];

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_responder.sv
// bus_responder: memory-side agent on the 16-bit CPU bus. Provides a
// zero-wait-state word RAM, an output FIFO mapped at IO_BASE+0, a STATUS
// register at IO_BASE+1 and, when BUS_RESP_TIMER_EN is defined, a
// free-running timer at IO_BASE+2. Without the macro the timer reads zero.
module bus_responder
    import bus_resp_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        rw,
    inout  wire  [15:0] data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0] r_ram [DEPTH];
    logic        r_ovf;

    logic        w_wr;
    logic        w_in_ram;
    logic        w_is_out;
    logic        w_is_status;
    logic        w_is_timer;
    logic [15:0] w_ram_q;
    logic [15:0] w_status;
    logic [15:0] w_timer_q;
    logic [15:0] w_rd_data;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_ovf_clr;
    logic [15:0] w_head;
    logic        w_full;
    logic        w_empty;
    logic [3:0]  w_count;

    // Address decode; anything not matched reads zero and ignores writes
    assign w_wr        = (rw == RW_WRITE);
    assign w_in_ram    = ({1'b0, address} < 17'(DEPTH));
    assign w_is_out    = (address == IO_BASE + 16'(OFS_OUT));
    assign w_is_status = (address == IO_BASE + 16'(OFS_STATUS));
    assign w_is_timer  = (address == IO_BASE + 16'(OFS_TIMER));

    // Word RAM write port; the read below is asynchronous so the CPU sees
    // data at the same edge, and a concurrent write only lands after it
    always_ff @(posedge clk) begin
        if (w_wr && w_in_ram) begin
            r_ram[address[AW-1:0]] <= data;
        end
    end
    assign w_ram_q = r_ram[address[AW-1:0]];

    // FIFO handshake: pops follow the consumer, pushes follow OUT_DATA writes
    assign w_pop     = !w_empty && out_ready;
    assign w_push    = w_wr && w_is_out;
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_ovf_clr = w_wr && w_is_status && data[ST_OVF];

    out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (w_push),
        .push_data (data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign out_data  = w_head;
    assign out_valid = !w_empty;

    // Sticky overflow flag; a new overflow outranks a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_status = pack_status(w_full, w_empty, r_ovf, w_count);

`ifdef BUS_RESP_TIMER_EN
    logic [15:0] r_timer;

    // Free-running counter; a bus write reloads it instead of incrementing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= 16'h0000;
        end else if (w_wr && w_is_timer) begin
            r_timer <= data;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end
    assign w_timer_q = r_timer;
`else
    assign w_timer_q = 16'h0000;
`endif

    // Read data selection; OUT_DATA, reserved and unmapped words return zero
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_in_ram) begin
            w_rd_data = w_ram_q;
        end else if (w_is_status) begin
            w_rd_data = w_status;
        end else if (w_is_timer) begin
            w_rd_data = w_timer_q;
        end
    end

    // Drive the shared bus only for CPU reads outside reset
    assign data = (!w_wr && !reset) ? w_rd_data : 16'hzzzz;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder (default parameters). A queue-based
// model tracks FIFO, ovf, RAM and timer; every clock edge steps the model.
module tb_bus_responder;

    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        tb_reset = 1'b1;
    logic [15:0] tb_addr = 16'h0000;
    logic        tb_rw = 1'b0;
    logic        tb_ready = 1'b0;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = 16'h0000;
    wire  [15:0] data;
    logic [15:0] out_data;
    logic        out_valid;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural reference state
    logic [15:0] m_ram [0:1023];
    logic [15:0] q [$];
    logic        m_ovf;
    logic [15:0] m_timer;

    assign data = drv_en ? drv_val : 16'hzzzz;

    always #5 clk = ~clk;

    bus_responder dut (
        .clk       (clk),
        .reset     (tb_reset),
        .address   (tb_addr),
        .rw        (tb_rw),
        .data      (data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (tb_ready)
    );

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = 16'h0000;
        s[0] = (q.size() == FD);
        s[1] = (q.size() == 0);
        s[2] = m_ovf;
        s[7:4] = 4'(q.size());
        return s;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a < 16'h0400) return m_ram[a[9:0]];
        if (a == 16'hFFF1) return m_status();
`ifdef BUS_RESP_TIMER_EN
        if (a == 16'hFFF2) return m_timer;
`endif
        return 16'h0000;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_timer = 16'h0000;
    endtask

    // One rising edge worth of behaviour, from the inputs currently applied
    task automatic model_step();
        bit pop, push, drop, clr;
        pop  = (q.size() != 0) && tb_ready;
        push = tb_rw && (tb_addr == 16'hFFF0);
        drop = push && (q.size() == FD) && !pop;
        clr  = tb_rw && (tb_addr == 16'hFFF1) && drv_val[2];
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(drv_val);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (tb_rw && tb_addr < 16'h0400) m_ram[tb_addr[9:0]] = drv_val;
`ifdef BUS_RESP_TIMER_EN
        if (tb_rw && tb_addr == 16'hFFF2) m_timer = drv_val;
        else m_timer = m_timer + 16'd1;
`endif
    endtask

    task automatic set_in(input logic rw, input logic [15:0] a, input logic [15:0] wd, input logic rdy);
        @(negedge clk);
        tb_rw = rw; tb_addr = a; drv_en = rw; drv_val = wd; tb_ready = rdy;
        #1;
        $display("txn t=%0t rw=%0d addr=%h wdata=%h ready=%0d", $time, rw, a, wd, rdy);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_step();
    endtask

    task automatic test_reset();
        tb_reset = 1'b1; tb_rw = 1'b0; tb_addr = 16'hFFF1; drv_en = 1'b1; drv_val = 16'h0000;
        model_reset();
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== 16'h0000) begin n_fails++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL reset_bus_hiz got=%h exp=0000 (only bench driving)", data); end
        @(negedge clk);
        tb_reset = 1'b0; drv_en = 1'b0;
        clk_edge();
        set_in(1'b0, 16'hFFF1, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0002) begin n_fails++; $display("FAIL reset_status got=%h exp=0002", data); end
        clk_edge();
    endtask

    task automatic test_ram();
        set_in(1'b1, 16'h0005, 16'hBEEF, 1'b0); clk_edge();
        set_in(1'b1, 16'h0006, 16'h1234, 1'b0); clk_edge();
        set_in(1'b0, 16'h0005, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'hBEEF) begin n_fails++; $display("FAIL ram_read5 got=%h exp=BEEF", data); end
        clk_edge();
        set_in(1'b0, 16'h0006, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h1234) begin n_fails++; $display("FAIL ram_read6 got=%h exp=1234", data); end
        clk_edge();
        set_in(1'b0, 16'h0800, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL unmapped_read got=%h exp=0000", data); end
        clk_edge();
        set_in(1'b0, 16'hFFF3, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL reserved_read got=%h exp=0000", data); end
        clk_edge();
        // Bench drives 0 over a word holding 1234: any responder drive would corrupt it
        set_in(1'b1, 16'h0006, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL write_no_drive got=%h exp=0000", data); end
        clk_edge();
        set_in(1'b0, 16'h0006, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL ram_rewrite got=%h exp=0000", data); end
        clk_edge();
    endtask

    task automatic test_fifo_basic();
        for (int i = 1; i <= 5; i++) begin
            set_in(1'b1, 16'hFFF0, 16'(i), 1'b0); clk_edge();
            if (i == 4) begin
                set_in(1'b0, 16'hFFF1, 16'h0000, 1'b0);
                n_checks++; if (data !== 16'h0041) begin n_fails++; $display("FAIL fifo_full_status got=%h exp=0041", data); end
                clk_edge();
            end
        end
        set_in(1'b0, 16'hFFF1, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0045) begin n_fails++; $display("FAIL fifo_ovf_status got=%h exp=0045", data); end
        clk_edge();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b0, 16'hFFF0, 16'h0000, 1'b1);
            n_checks++; if (out_valid !== 1'b1 || out_data !== 16'(i)) begin n_fails++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 16'(i)); end
            n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL out_data_read got=%h exp=0000", data); end
            clk_edge();
        end
        set_in(1'b0, 16'hFFF1, 16'h0000, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_fails++; $display("FAIL drained_empty got=%b/%h exp=0/0000", out_valid, out_data); end
        n_checks++; if (data !== 16'h0006) begin n_fails++; $display("FAIL drained_status got=%h exp=0006", data); end
        clk_edge();
    endtask

    task automatic test_push_pop_full();
        logic [15:0] exp_seq [4];
        set_in(1'b1, 16'hFFF1, 16'h0004, 1'b0); clk_edge();
        set_in(1'b0, 16'hFFF1, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0002) begin n_fails++; $display("FAIL ovf_clear got=%h exp=0002", data); end
        clk_edge();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 16'hFFF0, 16'(i * 16'h11), 1'b0); clk_edge();
        end
        set_in(1'b1, 16'hFFF0, 16'h00AA, 1'b1);
        n_checks++; if (out_data !== 16'h0011) begin n_fails++; $display("FAIL full_pushpop_head got=%h exp=0011", out_data); end
        clk_edge();
        set_in(1'b0, 16'hFFF1, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0041) begin n_fails++; $display("FAIL full_pushpop_status got=%h exp=0041", data); end
        clk_edge();
        exp_seq[0] = 16'h0022; exp_seq[1] = 16'h0033; exp_seq[2] = 16'h0044; exp_seq[3] = 16'h00AA;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 16'h0800, 16'h0000, 1'b1);
            n_checks++; if (out_data !== exp_seq[i]) begin n_fails++; $display("FAIL full_pushpop_order%0d got=%h exp=%h", i, out_data, exp_seq[i]); end
            clk_edge();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 16'hFFF0, 16'(16'h0100 + i), 1'b0); clk_edge();
        end
        set_in(1'b0, 16'hFFF1, 16'h0000, 1'b1);
        n_checks++; if (out_data !== 16'h0101) begin n_fails++; $display("FAIL pre_reset_head got=%h exp=0101", out_data); end
        clk_edge();
        // Three entries queued; assert reset between edges
        @(negedge clk); #2;
        tb_reset = 1'b1; tb_rw = 1'b0; tb_addr = 16'h0005; drv_en = 1'b1; drv_val = 16'h0000;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_fails++; $display("FAIL async_reset_out got=%b/%h exp=0/0000", out_valid, out_data); end
        n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL async_reset_hiz got=%h exp=0000 (only bench driving)", data); end
        model_reset();
        @(negedge clk);
        tb_reset = 1'b0; drv_en = 1'b0; tb_addr = 16'hFFF1; tb_ready = 1'b1;
        #1;
        n_checks++; if (data !== 16'h0002) begin n_fails++; $display("FAIL post_reset_status got=%h exp=0002", data); end
        clk_edge();
    endtask

    task automatic test_timer();
`ifdef BUS_RESP_TIMER_EN
        set_in(1'b1, 16'hFFF2, 16'hFFFE, 1'b0); clk_edge();
        set_in(1'b0, 16'hFFF2, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'hFFFE) begin n_fails++; $display("FAIL timer_load got=%h exp=FFFE", data); end
        clk_edge();
        set_in(1'b0, 16'hFFF2, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'hFFFF) begin n_fails++; $display("FAIL timer_inc got=%h exp=FFFF", data); end
        clk_edge();
        set_in(1'b0, 16'hFFF2, 16'h0000, 1'b0);
        n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL timer_wrap got=%h exp=0000", data); end
        clk_edge();
`else
        set_in(1'b1, 16'hFFF2, 16'h1234, 1'b0); clk_edge();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 16'hFFF2, 16'h0000, 1'b0);
            n_checks++; if (data !== 16'h0000) begin n_fails++; $display("FAIL timer_absent%0d got=%h exp=0000", i, data); end
            clk_edge();
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] a, exp;
        logic        rw;
        int          kind;
        for (int i = 0; i < 32; i++) begin
            set_in(1'b1, 16'(i), 16'($urandom), 1'b0); clk_edge();
        end
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: a = 16'($urandom_range(0, 31));
                4, 5:       a = 16'hFFF0;
                6:          a = 16'hFFF1;
                7:          a = 16'hFFF2;
                8:          a = 16'hFFF3;
                default:    a = 16'($urandom_range(16'h0400, 16'hFFEF));
            endcase
            rw = 1'($urandom_range(0, 1));
            set_in(rw, a, 16'($urandom), 1'($urandom_range(0, 1)));
            n_checks++;
            if (out_valid !== (q.size() != 0) || out_data !== ((q.size() != 0) ? q[0] : 16'h0000)) begin
                n_fails++;
                $display("FAIL rand_out%0d got=%b/%h exp=%b/%h", i, out_valid, out_data, q.size() != 0, (q.size() != 0) ? q[0] : 16'h0000);
            end
            if (!rw) begin
                exp = m_read(a);
                n_checks++;
                if (data !== exp) begin n_fails++; $display("FAIL rand_read%0d addr=%h got=%h exp=%h", i, a, data, exp); end
            end
            clk_edge();
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_basic();
        test_push_pop_full();
        test_async_reset();
        test_timer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
